// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 scan-code receiver.
// The event layout is {ext, rel, code} so that it packs into a 10-bit FIFO word.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } ps2_event_t;

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK
    } dec_state_e;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with a sticky overflow flag.
// DEPTH does not need to be a power of two; pointers wrap explicitly.
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_valid_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    output logic                       rd_valid_o,
    input  logic                       rd_ready_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       overflow_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;
    logic             full, pop, push;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full = (count_q == CNT_W'(DEPTH));
    assign pop  = (count_q != '0) && rd_ready_i;
    // A pop frees the slot in the same cycle, so a push into a full FIFO is legal then.
    assign push = wr_valid_i && (!full || pop);

    // NOTE: storage has no reset; only the pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (wr_valid_i && full && !pop) overflow_q <= 1'b1;
        end
    end

    assign rd_valid_o = (count_q != '0);
    assign rd_data_o  = mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver: synchroniser, 11-bit deserialiser with stall timeout,
// Set-2 prefix decoder with optional typematic suppression, and an event FIFO.
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH      = 8,
    parameter int SYNC_STAGES     = 3,
    parameter int TIMEOUT_CYCLES  = 50000,
    parameter int SUPPRESS_REPEAT = 0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            ps2_clk,
    input  logic                            ps2_data,
    output logic                            ev_valid,
    input  logic                            ev_ready,
    output logic [7:0]                      ev_code,
    output logic                            ev_ext,
    output logic                            ev_rel,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic                            overflow,
    output logic                            err_frame,
    output logic                            err_timeout
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES);

    logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
    logic [3:0]             count_q, count_d;
    logic [9:0]             bits_q, bits_d;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic                   err_frame_q, err_frame_d;
    logic                   err_timeout_q, err_timeout_d;
    dec_state_e             state_q, state_d;
    logic [8:0]             held_q, held_d;
    logic                   held_valid_q, held_valid_d;

    logic       sample, data_s, byte_ok, dec_clear, emit;
    logic [7:0] rx_byte;
    ps2_event_t ev, head;

    // Oldest stage still high while the next is low marks a ps2_clk falling edge.
    assign sample  = clk_sync_q[SYNC_STAGES-1] && !clk_sync_q[SYNC_STAGES-2];
    assign data_s  = data_sync_q[SYNC_STAGES-1];
    assign rx_byte = bits_q[8:1];

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        count_d       = count_q;
        bits_d        = bits_q;
        to_cnt_d      = to_cnt_q;
        err_frame_d   = 1'b0;
        err_timeout_d = 1'b0;
        byte_ok       = 1'b0;
        dec_clear     = 1'b0;
        if (sample) begin
            to_cnt_d = '0;
            if (count_q != 4'd10) begin
                bits_d[count_q] = data_s;
                count_d         = count_q + 4'd1;
            end else begin
                count_d = '0;
                if (!bits_q[0] && data_s && (^bits_q[9:1])) begin
                    byte_ok = 1'b1;
                end else begin
                    err_frame_d = 1'b1;
                    dec_clear   = 1'b1;
                end
            end
        end else if (count_q == '0) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES-1)) begin
            count_d       = '0;
            to_cnt_d      = '0;
            err_timeout_d = 1'b1;
            dec_clear     = 1'b1;
        end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    always_comb begin
        state_d      = state_q;
        held_d       = held_q;
        held_valid_d = held_valid_q;
        emit         = 1'b0;
        ev           = '{ext: 1'b0, rel: 1'b0, code: rx_byte};
        if (dec_clear) begin
            state_d = IDLE;
        end else if (byte_ok) begin
            unique case (state_q)
                IDLE: begin
                    if (rx_byte == PS2_EXT)      state_d = EXT;
                    else if (rx_byte == PS2_BRK) state_d = BRK;
                    else                         emit    = 1'b1;
                end
                EXT: begin
                    if (rx_byte == PS2_BRK)      state_d = EXT_BRK;
                    else if (rx_byte != PS2_EXT) begin
                        emit    = 1'b1;
                        ev.ext  = 1'b1;
                        state_d = IDLE;
                    end
                end
                BRK: begin
                    if (rx_byte != PS2_BRK) begin
                        emit    = 1'b1;
                        ev.rel  = 1'b1;
                        state_d = IDLE;
                    end
                end
                EXT_BRK: begin
                    emit    = 1'b1;
                    ev.ext  = 1'b1;
                    ev.rel  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
            // Typematic repeats show up as a make of the key already held down.
            if (SUPPRESS_REPEAT != 0 && emit) begin
                if (!ev.rel) begin
                    if (held_valid_q && held_q == {ev.ext, ev.code}) begin
                        emit = 1'b0;
                    end else begin
                        held_d       = {ev.ext, ev.code};
                        held_valid_d = 1'b1;
                    end
                end else if (held_valid_q && held_q == {ev.ext, ev.code}) begin
                    held_valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q    <= '1;
            data_sync_q   <= '1;
            count_q       <= '0;
            bits_q        <= '0;
            to_cnt_q      <= '0;
            err_frame_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            state_q       <= IDLE;
            held_q        <= '0;
            held_valid_q  <= 1'b0;
        end else begin
            clk_sync_q    <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            data_sync_q   <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
            count_q       <= count_d;
            bits_q        <= bits_d;
            to_cnt_q      <= to_cnt_d;
            err_frame_q   <= err_frame_d;
            err_timeout_q <= err_timeout_d;
            state_q       <= state_d;
            held_q        <= held_d;
            held_valid_q  <= held_valid_d;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(ps2_event_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .wr_valid_i (emit),
        .wr_data_i  (ev),
        .rd_valid_o (ev_valid),
        .rd_ready_i (ev_ready),
        .rd_data_o  (head),
        .count_o    (fifo_count),
        .overflow_o (overflow)
    );

    assign ev_code     = ev_valid ? head.code : '0;
    assign ev_ext      = ev_valid && head.ext;
    assign ev_rel      = ev_valid && head.rel;
    assign err_frame   = err_frame_q;
    assign err_timeout = err_timeout_q;

endmodule
